ps2_scan_rx: RTL
================

// Module: ps2_scan_rx
// PURPOSE
//  PS/2 keyboard receiver: samples the keyboard's ps2_clk/ps2_data pair, deframes 11-bit frames,
//  decodes make/break/extended prefixes, and presents a held scan code on key_stroke. This is
//  the producer feeding key_stroke into the note-display VGA block. A code holds while the key is
//  down. It returns to 8'h00 on release, which makes the display fall back to its default note.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal synced samples needed before ps2_clk_f changes
//  TIMEOUT_CYCLES  200000  clk cycles with no falling edge before a partial frame is aborted
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, synchronous, active-high
//  ps2_clk      in   1  keyboard clock, asynchronous, open-drain (idle high)
//  ps2_data     in   1  keyboard data, asynchronous, open-drain (idle high)
//  key_stroke   out  8  scan code of the currently held key; 8'h00 when none is held
//  key_ext      out  1  1 when the held key's make code was prefixed by E0
//  key_valid    out  1  one-cycle pulse when key_stroke/key_ext load a new make code
//  key_release  out  1  one-cycle pulse when a break code clears key_stroke
//  frame_err    out  1  one-cycle pulse on a start, parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, prefix flags ext_p/brk_p cleared, filter state = 1 (idle).
//   Reset mid-frame discards the partial frame and emits no pulse.
//  Input conditioning: both inputs go through a 2-FF synchroniser.
//   - ps2_clk_f flips only after FILTER_LEN consecutive synced samples disagree with it.
//   - fall = 1-cycle strobe on a ps2_clk_f 1->0 transition; data is sampled from synced ps2_data.
//   - Glitches shorter than FILTER_LEN cycles produce no strobe.
//  FSM, advanced only on fall unless noted:
//   - IDLE: sampled bit 0 -> DATA with bit_cnt=0. Sampled bit 1 -> stay in IDLE, no error.
//   - DATA: shift bits in LSB first; after 8 bits -> PARITY.
//   - PARITY: store the parity bit -> STOP.
//   - STOP: data^parity must have odd parity AND the stop bit must be 1 -> byte_done.
//     Otherwise pulse frame_err. In both cases -> IDLE.
//   - Any state except IDLE: timer counts clk cycles since the last fall. When it reaches
//     TIMEOUT_CYCLES: frame_err pulse, -> IDLE. Timer clears on every fall and in IDLE.
//  Decode on byte_done (outputs registered, visible 1 cycle after the STOP fall):
//   - 8'hE0: set ext_p, no output change.
//   - 8'hF0: set brk_p, no output change.
//   - other byte b with brk_p=1: if b==key_stroke and ext_p==key_ext then key_stroke<=0,
//     key_ext<=0, key_release pulse. Otherwise ignore (a different key was released).
//     Clear ext_p and brk_p in both cases.
//   - other byte b with brk_p=0: key_stroke<=b, key_ext<=ext_p, key_valid pulse (typematic
//     repeats of the same code pulse again). Clear ext_p.
//  frame_err does not clear ext_p/brk_p; a prefix survives one corrupted frame.
//  Error and byte_done never occur in the same cycle. Pulses are exactly 1 cycle wide.
//  Rollover is not tracked: only the most recent make code is held.
// STRUCTURE
//  Shared constants header (alongside the character constants):
//   `PS2_BREAK 8'hF0, `PS2_EXT 8'hE0, and FSM state encodings PS2_IDLE/DATA/PARITY/STOP (2 bits).
//  Sub-module ps2_filter (params FILTER_LEN): synchroniser + deglitch + fall strobe + synced data.
//   Instantiated once here. The frame FSM, timer and decoder stay in ps2_scan_rx.
//  Counters: bit_cnt 3 bits; timer $clog2(TIMEOUT_CYCLES+1) bits, saturating.
// TESTING  (bench BFM drives 12.5 kHz PS/2 frames, FILTER_LEN=8, TIMEOUT_CYCLES=2000 for sim)
//  1. Frame 0x1C (parity 0, stop 1) -> key_stroke=8'h1C, key_ext=0, key_valid high 1 cycle
//     after the stop fall.
//  2. 1C, then F0, then 1C -> key_stroke=8'h00, key_release 1 pulse, no key_valid on F0 or
//     on the second 1C.
//  3. 1C, then 0x23 with wrong parity -> frame_err 1 pulse, key_stroke stays 8'h1C.
//     A following good 0x23 -> 8'h23.
//  4. E0 75 -> key_stroke=8'h75, key_ext=1. Then E0 F0 75 -> key_stroke=0, key_ext=0,
//     key_release pulse.
//  5. 5-cycle low glitch on ps2_clk while idle and mid-frame -> no bit shifted;
//     a 0x3B frame still decodes as 8'h3B.
//  6. Send start + 4 bits, then hold ps2_clk high -> frame_err exactly TIMEOUT_CYCLES after
//     the last fall. Next good 0x42 -> 8'h42.
//  7. Assert rst for 1 cycle mid-frame -> outputs 0, no pulses. Next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_scan_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_rx_pkg
//  Purpose  : Shared constants for the PS/2 scan-code receiver: prefix bytes,
//             frame FSM state encodings, line idle level and a parity helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ps2_scan_rx_pkg;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

    localparam logic [1:0] PS2_IDLE      = 2'd0;
    localparam logic [1:0] PS2_DATA      = 2'd1;
    localparam logic [1:0] PS2_PARITY    = 2'd2;
    localparam logic [1:0] PS2_STOP      = 2'd3;

    // Open-drain lines float high when nobody drives them.
    localparam logic       PS2_LINE_IDLE = 1'b1;

    // A frame is good when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{p, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_rx_if
//  Purpose  : Bundles the keyboard line pair and the decoded key outputs.
//  Ports    : ps2_clk, ps2_data   keyboard lines (into the receiver)
//             key_stroke, key_ext held key code / E0 flag
//             key_valid, key_release, frame_err  one-cycle pulses
//             modport master : receiver side; modport slave : keyboard/consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_scan_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_stroke;
    logic       key_ext;
    logic       key_valid;
    logic       key_release;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output key_stroke, key_ext, key_valid, key_release, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  key_stroke, key_ext, key_valid, key_release, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_filter
//  Purpose  : Synchronises ps2_clk/ps2_data, deglitches the clock and emits a
//             one-cycle strobe on each filtered falling edge with the data bit.
//  Ports    : clk, rst      system clock, sync active-high reset
//             ps2_clk_i     raw keyboard clock
//             ps2_data_i    raw keyboard data
//             fall_o        1-cycle strobe on filtered clock 1->0
//             data_o        synced data bit, valid while fall_o is high
//  Revision : 1.0  initial release
// ============================================================================
module ps2_filter
    import ps2_scan_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic ps2_clk_i,
    input  wire logic ps2_data_i,
    output logic      fall_o,
    output logic      data_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_f_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fall_q;
    logic             data_q;
    logic             w_flip;

    // The filtered clock flips on the FILTER_LEN-th consecutive disagreeing sample.
    assign w_flip = (clk_sync_q[1] != clk_f_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= {2{PS2_LINE_IDLE}};
            data_sync_q <= {2{PS2_LINE_IDLE}};
            clk_f_q     <= PS2_LINE_IDLE;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
            data_q      <= PS2_LINE_IDLE;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            if (clk_sync_q[1] == clk_f_q) begin
                cnt_q <= '0;
            end else if (w_flip) begin
                cnt_q   <= '0;
                clk_f_q <= ~clk_f_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            fall_q <= w_flip && clk_f_q;
            data_q <= data_sync_q[1];
        end
    end

    assign fall_o = fall_q;
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_rx
//  Purpose  : PS/2 keyboard receiver. Deframes 11-bit frames, checks parity
//             and stop bit, aborts stalled frames, and decodes E0/F0 prefixes
//             into a held scan code.
//  Ports    : clk, rst   system clock, sync active-high reset
//             bus        ps2_scan_rx_if.master (ps2 lines in, key outputs out)
//  Revision : 1.0  initial release
// ============================================================================
module ps2_scan_rx
    import ps2_scan_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ps2_scan_rx_if.master  bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic               w_fall;
    logic               w_data;
    logic [1:0]         state_q, state_d;
    logic [7:0]         shift_q;
    logic [2:0]         bit_cnt_q;
    logic               par_q;
    logic [TIMER_W-1:0] timer_q;
    logic               w_timeout;
    logic               w_frame_ok;
    logic               w_byte_done;
    logic               w_err;

    logic [7:0]         key_stroke_q, key_stroke_d;
    logic               key_ext_q, key_ext_d;
    logic               key_valid_q, key_valid_d;
    logic               key_release_q, key_release_d;
    logic               frame_err_q, frame_err_d;
    logic               ext_p_q, ext_p_d;
    logic               brk_p_q, brk_p_d;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (bus.ps2_clk),
        .ps2_data_i (bus.ps2_data),
        .fall_o     (w_fall),
        .data_o     (w_data)
    );

    // A falling edge always wins over a coinciding timeout so the frame's own
    // outcome is reported and error/byte_done can never overlap.
    assign w_timeout = (state_q != PS2_IDLE) && !w_fall &&
                       (timer_q == TIMER_W'(TIMEOUT_CYCLES));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= PS2_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (w_timeout) begin
            state_d = PS2_IDLE;
        end else if (w_fall) begin
            case (state_q)
                PS2_IDLE:   if (!w_data) state_d = PS2_DATA;
                PS2_DATA:   if (bit_cnt_q == 3'd7) state_d = PS2_PARITY;
                PS2_PARITY: state_d = PS2_STOP;
                default:    state_d = PS2_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_frame_ok  = odd_parity_ok(shift_q, par_q) && w_data;
        w_byte_done = w_fall && (state_q == PS2_STOP) && w_frame_ok;
        w_err       = (w_fall && (state_q == PS2_STOP) && !w_frame_ok) || w_timeout;
    end

    // ---------------- Frame datapath and stall timer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            if ((state_q == PS2_IDLE) || w_fall)          timer_q <= '0;
            else if (timer_q != TIMER_W'(TIMEOUT_CYCLES)) timer_q <= timer_q + 1'b1;

            if (w_fall) begin
                case (state_q)
                    PS2_IDLE:   bit_cnt_q <= '0;
                    PS2_DATA: begin
                        shift_q   <= {w_data, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    PS2_PARITY: par_q <= w_data;
                    default:    ;
                endcase
            end
        end
    end

    // ---------------- Scan-code decoder ----------------
    always_comb begin
        key_stroke_d  = key_stroke_q;
        key_ext_d     = key_ext_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        frame_err_d   = w_err;
        ext_p_d       = ext_p_q;
        brk_p_d       = brk_p_q;
        if (w_byte_done) begin
            if (shift_q == PS2_EXT) begin
                ext_p_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
                brk_p_d = 1'b1;
            end else if (brk_p_q) begin
                // Only the release of the held key clears the output.
                if ((shift_q == key_stroke_q) && (ext_p_q == key_ext_q)) begin
                    key_stroke_d  = 8'h00;
                    key_ext_d     = 1'b0;
                    key_release_d = 1'b1;
                end
                ext_p_d = 1'b0;
                brk_p_d = 1'b0;
            end else begin
                key_stroke_d = shift_q;
                key_ext_d    = ext_p_q;
                key_valid_d  = 1'b1;
                ext_p_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_stroke_q  <= 8'h00;
            key_ext_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            frame_err_q   <= 1'b0;
            ext_p_q       <= 1'b0;
            brk_p_q       <= 1'b0;
        end else begin
            key_stroke_q  <= key_stroke_d;
            key_ext_q     <= key_ext_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            frame_err_q   <= frame_err_d;
            ext_p_q       <= ext_p_d;
            brk_p_q       <= brk_p_d;
        end
    end

    assign bus.key_stroke  = key_stroke_q;
    assign bus.key_ext     = key_ext_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_release = key_release_q;
    assign bus.frame_err   = frame_err_q;

endmodule
`default_nettype wire
